uitpg_ctrl: RTL and testbench
=============================

UITPG_CTRL -- requirements
Module: uitpg_ctrl

Interface
REQ-001 SHALL provide parameter PAT_NUM, default 12: number of selectable test patterns, legal range 2..16.
REQ-002 SHALL provide parameter FCNT_W, default 16: frame counter width.
REQ-003 SHALL have port I_tpg_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port I_tpg_rstn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port I_tpg_vs, input, 1: vertical sync, active high; rising edge marks a frame boundary.
REQ-006 SHALL have port I_cfg_valid, input, 1: configuration request valid.
REQ-007 SHALL have port O_cfg_ready, output, 1: controller can accept a configuration.
REQ-008 SHALL have port I_cfg_auto, input, 1: requested mode, 1 = auto-cycle, 0 = manual hold.
REQ-009 SHALL have port I_cfg_pat, input, 4: requested pattern index.
REQ-010 SHALL have port I_cfg_dwell, input, 8: frames per pattern in auto mode.
REQ-011 SHALL have port O_pat_sel, output, 4: active pattern index driven to the pattern generator.
REQ-012 SHALL have port O_pat_upd, output, 1: one-cycle pulse when O_pat_sel is (re)loaded.
REQ-013 SHALL have port O_auto, output, 1: active mode, 1 = auto.
REQ-014 SHALL have port O_frame_cnt, output, FCNT_W: count of VS rising edges.

Function
REQ-015 SHALL register I_tpg_vs into vs_r and detect a frame edge, vs_edge = !vs_r && I_tpg_vs.
REQ-016 SHALL accept a configuration only on a cycle where I_cfg_valid && O_cfg_ready.
- On acceptance, it captures auto/pat/dwell into shadow registers, sets a pending flag, and drives O_cfg_ready low the next cycle.
REQ-017 SHALL clamp a captured I_cfg_pat >= PAT_NUM to 0.
REQ-018 SHALL apply a pending configuration only on a vs_edge occurring while the pending flag was already set before that cycle.
- An acceptance and a vs_edge in the same cycle apply at the following vs_edge.
REQ-019 SHALL, on apply, perform all of the following in the cycle after the vs_edge:
- load O_pat_sel from shadow, O_auto from shadow, and the dwell register from shadow;
- clear the dwell counter and the pending flag;
- drive O_cfg_ready high;
- pulse O_pat_upd, even if the index is unchanged.
REQ-020 SHALL use an FSM with states MANUAL and AUTO, selected by O_auto; the pending flag is orthogonal to the state.
REQ-021 SHALL, in MANUAL, hold O_pat_sel constant and leave the dwell counter at 0.
REQ-022 SHALL, in AUTO, increment the dwell counter on each vs_edge without an apply, using effective dwell D = max(dwell,1).
- When the counter equals D-1 at a vs_edge, the block advances O_pat_sel, clears the counter and pulses O_pat_upd.
REQ-023 SHALL advance O_pat_sel by 1, wrapping from PAT_NUM-1 to 0.
REQ-024 SHALL give apply priority over auto advance on the same vs_edge.
REQ-025 SHALL increment O_frame_cnt on every vs_edge, wrapping all-ones to 0.
REQ-026 SHALL make all outputs registered, with latency of exactly one cycle from the sampling clock edge of vs_edge to the updated O_pat_sel/O_pat_upd.
REQ-027 SHALL never assert O_pat_upd on two consecutive cycles.

Reset
REQ-028 SHALL, when I_tpg_rstn is sampled low, set all of the following on that clock edge:
- O_pat_sel=0, O_pat_upd=0, O_auto=0 (MANUAL), O_cfg_ready=1, O_frame_cnt=0;
- dwell=0, dwell counter=0, pending flag=0, vs_r=1.
REQ-029 SHALL discard any pending configuration on reset asserted mid-frame.
REQ-030 SHALL, because vs_r resets to 1, report no vs_edge when I_tpg_vs is already high on the first cycle after reset.

Verification
REQ-031 SHALL cover manual load: accept {auto=0,pat=5} mid-frame -> O_cfg_ready=0 until next vs_edge; one cycle later O_pat_sel=5, O_pat_upd pulse, O_cfg_ready=1; pattern stays 5 over 4 further frames.
REQ-032 SHALL cover auto cycling: apply {auto=1,pat=10,dwell=2}, PAT_NUM=12 -> O_pat_sel sequence 10,10,11,11,0,0,1 on successive frames, with one O_pat_upd per change.
REQ-033 SHALL cover dwell 0 and clamp: apply {auto=1,pat=14,dwell=0} -> O_pat_sel=0 at apply, then 1,2,3 on each following frame.
REQ-034 SHALL cover simultaneous events: I_cfg_valid on the exact vs_edge cycle while in AUTO due to advance -> auto advance happens now; config applies at the next vs_edge; a second I_cfg_valid while pending is not accepted.
REQ-035 SHALL cover reset mid-operation: reset during AUTO with a pending config, with I_tpg_vs held high -> all outputs at reset values; no O_pat_upd and no O_frame_cnt increment until the next genuine VS rising edge.
REQ-036 SHALL cover frame counter wrap: preload via 65535 vs_edges -> O_frame_cnt=65535, then 0 on the next edge.

Source files
------------

// File: rtl/uitpg_ctrl_if.sv
// Configuration handshake and pattern-select bundle shared by the
// test-pattern controller and whoever drives or observes it.
interface uitpg_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_auto;
  logic [3:0] cfg_pat;
  logic [7:0] cfg_dwell;
  logic [3:0] pat_sel;
  logic       pat_upd;
  logic       auto_md;

  modport master (
    output cfg_valid, cfg_auto, cfg_pat, cfg_dwell,
    input  cfg_ready, pat_sel, pat_upd, auto_md
  );

  modport slave (
    input  cfg_valid, cfg_auto, cfg_pat, cfg_dwell,
    output cfg_ready, pat_sel, pat_upd, auto_md
  );
endinterface

// File: rtl/uitpg_ctrl.sv
// Test-pattern generator controller: frame-synchronous pattern selection
// in manual-hold or auto-cycle mode, reconfigured only on VS rising edges.
module uitpg_ctrl #(
  parameter int PAT_NUM = 12,
  parameter int FCNT_W  = 16
) (
  input  logic              I_tpg_clk,
  input  logic              I_tpg_rstn,
  input  logic              I_tpg_vs,
  input  logic              I_cfg_valid,
  output logic              O_cfg_ready,
  input  logic              I_cfg_auto,
  input  logic [3:0]        I_cfg_pat,
  input  logic [7:0]        I_cfg_dwell,
  output logic [3:0]        O_pat_sel,
  output logic              O_pat_upd,
  output logic              O_auto,
  output logic [FCNT_W-1:0] O_frame_cnt
);

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

  localparam logic [4:0] PN = 5'(PAT_NUM);

  uitpg_ctrl_if w_if ();

  logic              r_vs;
  logic              r_ready;
  logic              r_pend;
  logic              r_sh_auto;
  logic [3:0]        r_sh_pat;
  logic [7:0]        r_sh_dwell;
  state_t            r_state;
  logic [3:0]        r_sel;
  logic              r_upd;
  logic [7:0]        r_dwell;
  logic [7:0]        r_cnt;
  logic [FCNT_W-1:0] r_fcnt;

  logic              w_vs_edge;
  logic              w_acc;
  logic              w_apply;
  logic [3:0]        w_pat_clamp;
  logic [7:0]        w_deff;
  state_t            w_state_nxt;
  logic [3:0]        w_sel_nxt;
  logic              w_upd_nxt;
  logic [7:0]        w_cnt_nxt;
  logic [7:0]        w_dwell_nxt;

  assign w_if.cfg_valid = I_cfg_valid;
  assign w_if.cfg_auto  = I_cfg_auto;
  assign w_if.cfg_pat   = I_cfg_pat;
  assign w_if.cfg_dwell = I_cfg_dwell;
  assign w_if.cfg_ready = r_ready;
  assign w_if.pat_sel   = r_sel;
  assign w_if.pat_upd   = r_upd;
  assign w_if.auto_md   = (r_state == AUTO);

  assign O_cfg_ready = w_if.cfg_ready;
  assign O_pat_sel   = w_if.pat_sel;
  assign O_pat_upd   = w_if.pat_upd;
  assign O_auto      = w_if.auto_md;
  assign O_frame_cnt = r_fcnt;

  // r_vs resets high so a VS already asserted out of reset is not a frame edge
  assign w_vs_edge   = !r_vs && I_tpg_vs;
  assign w_acc       = w_if.cfg_valid && r_ready;
  assign w_apply     = w_vs_edge && r_pend;
  assign w_pat_clamp = ({1'b0, w_if.cfg_pat} >= PN) ? 4'd0 : w_if.cfg_pat;
  assign w_deff      = (r_dwell == 8'd0) ? 8'd1 : r_dwell;

  always_ff @(posedge I_tpg_clk) begin
    if (!I_tpg_rstn) begin
      r_vs   <= 1'b1;
      r_fcnt <= '0;
    end else begin
      r_vs <= I_tpg_vs;
      if (w_vs_edge) r_fcnt <= r_fcnt + 1'b1;
    end
  end

  // Acceptance needs ready, which is only high with nothing pending, so
  // accept and apply are mutually exclusive in any one cycle.
  always_ff @(posedge I_tpg_clk) begin
    if (!I_tpg_rstn) begin
      r_ready    <= 1'b1;
      r_pend     <= 1'b0;
      r_sh_auto  <= 1'b0;
      r_sh_pat   <= 4'd0;
      r_sh_dwell <= 8'd0;
    end else if (w_acc) begin
      r_ready    <= 1'b0;
      r_pend     <= 1'b1;
      r_sh_auto  <= w_if.cfg_auto;
      r_sh_pat   <= w_pat_clamp;
      r_sh_dwell <= w_if.cfg_dwell;
    end else if (w_apply) begin
      r_ready <= 1'b1;
      r_pend  <= 1'b0;
    end
  end

  always_ff @(posedge I_tpg_clk) begin
    if (!I_tpg_rstn) r_state <= MANUAL;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_apply) w_state_nxt = r_sh_auto ? AUTO : MANUAL;
  end

  // Apply wins over auto advance on a shared frame edge.
  always_comb begin
    w_sel_nxt   = r_sel;
    w_upd_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_dwell_nxt = r_dwell;
    if (w_apply) begin
      w_sel_nxt   = r_sh_pat;
      w_upd_nxt   = 1'b1;
      w_cnt_nxt   = 8'd0;
      w_dwell_nxt = r_sh_dwell;
    end else if (r_state == MANUAL) begin
      w_cnt_nxt = 8'd0;
    end else if (w_vs_edge) begin
      if (r_cnt == w_deff - 8'd1) begin
        w_sel_nxt = ({1'b0, r_sel} == PN - 5'd1) ? 4'd0 : r_sel + 4'd1;
        w_upd_nxt = 1'b1;
        w_cnt_nxt = 8'd0;
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge I_tpg_clk) begin
    if (!I_tpg_rstn) begin
      r_sel   <= 4'd0;
      r_upd   <= 1'b0;
      r_cnt   <= 8'd0;
      r_dwell <= 8'd0;
    end else begin
      r_sel   <= w_sel_nxt;
      r_upd   <= w_upd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dwell <= w_dwell_nxt;
    end
  end

endmodule

// File: tb/tb_uitpg_ctrl.sv
// Directed bench for uitpg_ctrl: manual load, auto cycling, dwell/clamp,
// simultaneous events, mid-frame reset and frame counter wrap.
module tb_uitpg_ctrl;
  // A narrow frame counter keeps the wrap scenario short in cycles.
  localparam int FW = 10;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          vs   = 1'b0;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fexp;
  int            nvec = 0;
  int            nerr = 0;

  uitpg_ctrl_if tif ();

  uitpg_ctrl #(.PAT_NUM(12), .FCNT_W(FW)) dut (
    .I_tpg_clk   (clk),
    .I_tpg_rstn  (rstn),
    .I_tpg_vs    (vs),
    .I_cfg_valid (tif.cfg_valid),
    .O_cfg_ready (tif.cfg_ready),
    .I_cfg_auto  (tif.cfg_auto),
    .I_cfg_pat   (tif.cfg_pat),
    .I_cfg_dwell (tif.cfg_dwell),
    .O_pat_sel   (tif.pat_sel),
    .O_pat_upd   (tif.pat_upd),
    .O_auto      (tif.auto_md),
    .O_frame_cnt (fcnt)
  );

  always #5 clk = ~clk;

  task automatic cfg(input logic a, input logic [3:0] p, input logic [7:0] d);
    @(negedge clk);
    tif.cfg_valid = 1'b1; tif.cfg_auto = a; tif.cfg_pat = p; tif.cfg_dwell = d;
    @(negedge clk);
    tif.cfg_valid = 1'b0;
  endtask

  // One frame: upd/sel right after the edge, upd2 one cycle later.
  task automatic vs_pulse(output logic upd, output logic [3:0] sel, output logic upd2);
    @(negedge clk); vs = 1'b1;
    @(negedge clk); upd = tif.pat_upd; sel = tif.pat_sel; vs = 1'b0;
    @(negedge clk); upd2 = tif.pat_upd;
    repeat (2) @(negedge clk);
    fexp = fexp + 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (tif.pat_sel !== 4'd0) begin nerr++; $display("FAIL reset_sel: got %0d want 0", tif.pat_sel); end
    nvec++; if (tif.pat_upd !== 1'b0) begin nerr++; $display("FAIL reset_upd: got %0b want 0", tif.pat_upd); end
    nvec++; if (tif.auto_md !== 1'b0) begin nerr++; $display("FAIL reset_auto: got %0b want 0", tif.auto_md); end
    nvec++; if (tif.cfg_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %0b want 1", tif.cfg_ready); end
    nvec++; if (fcnt !== '0) begin nerr++; $display("FAIL reset_fcnt: got %0d want 0", fcnt); end
    rstn = 1'b1;
    fexp = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_manual();
    logic u, u2; logic [3:0] s;
    cfg(1'b0, 4'd5, 8'd0);
    nvec++; if (tif.cfg_ready !== 1'b0) begin nerr++; $display("FAIL man_ready_lo: got %0b want 0", tif.cfg_ready); end
    repeat (3) @(negedge clk);
    nvec++; if (tif.cfg_ready !== 1'b0) begin nerr++; $display("FAIL man_ready_hold: got %0b want 0", tif.cfg_ready); end
    nvec++; if (tif.pat_sel !== 4'd0) begin nerr++; $display("FAIL man_sel_pre: got %0d want 0", tif.pat_sel); end
    vs_pulse(u, s, u2);
    nvec++; if (s !== 4'd5) begin nerr++; $display("FAIL man_sel: got %0d want 5", s); end
    nvec++; if (u !== 1'b1) begin nerr++; $display("FAIL man_upd: got %0b want 1", u); end
    nvec++; if (u2 !== 1'b0) begin nerr++; $display("FAIL man_upd_once: got %0b want 0", u2); end
    nvec++; if (tif.cfg_ready !== 1'b1) begin nerr++; $display("FAIL man_ready_hi: got %0b want 1", tif.cfg_ready); end
    nvec++; if (tif.auto_md !== 1'b0) begin nerr++; $display("FAIL man_auto: got %0b want 0", tif.auto_md); end
    for (int i = 0; i < 4; i++) begin
      vs_pulse(u, s, u2);
      nvec++; if (s !== 4'd5) begin nerr++; $display("FAIL man_hold_sel[%0d]: got %0d want 5", i, s); end
      nvec++; if (u !== 1'b0) begin nerr++; $display("FAIL man_hold_upd[%0d]: got %0b want 0", i, u); end
    end
    nvec++; if (fcnt !== fexp) begin nerr++; $display("FAIL man_fcnt: got %0d want %0d", fcnt, fexp); end
  endtask

  task automatic test_auto();
    logic u, u2; logic [3:0] s;
    logic [3:0] esel [6];
    logic       eupd [6];
    esel = '{4'd10, 4'd11, 4'd11, 4'd0, 4'd0, 4'd1};
    eupd = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cfg(1'b1, 4'd10, 8'd2);
    vs_pulse(u, s, u2);
    nvec++; if (s !== 4'd10) begin nerr++; $display("FAIL auto_apply_sel: got %0d want 10", s); end
    nvec++; if (u !== 1'b1) begin nerr++; $display("FAIL auto_apply_upd: got %0b want 1", u); end
    nvec++; if (tif.auto_md !== 1'b1) begin nerr++; $display("FAIL auto_mode: got %0b want 1", tif.auto_md); end
    for (int i = 0; i < 6; i++) begin
      vs_pulse(u, s, u2);
      nvec++; if (s !== esel[i]) begin nerr++; $display("FAIL auto_sel[%0d]: got %0d want %0d", i, s, esel[i]); end
      nvec++; if (u !== eupd[i]) begin nerr++; $display("FAIL auto_upd[%0d]: got %0b want %0b", i, u, eupd[i]); end
      nvec++; if (u2 !== 1'b0) begin nerr++; $display("FAIL auto_upd2[%0d]: got %0b want 0", i, u2); end
    end
  endtask

  task automatic test_dwell0();
    logic u, u2; logic [3:0] s;
    cfg(1'b1, 4'd14, 8'd0);
    vs_pulse(u, s, u2);
    nvec++; if (s !== 4'd0) begin nerr++; $display("FAIL d0_clamp_sel: got %0d want 0", s); end
    nvec++; if (u !== 1'b1) begin nerr++; $display("FAIL d0_clamp_upd: got %0b want 1", u); end
    for (int i = 1; i <= 3; i++) begin
      vs_pulse(u, s, u2);
      nvec++; if (s !== 4'(i)) begin nerr++; $display("FAIL d0_sel[%0d]: got %0d want %0d", i, s, i); end
      nvec++; if (u !== 1'b1) begin nerr++; $display("FAIL d0_upd[%0d]: got %0b want 1", i, u); end
    end
  endtask

  task automatic test_simul();
    logic u, u2; logic [3:0] s;
    // AUTO, dwell 0, sel 3: every edge advances; request lands on that edge
    @(negedge clk);
    vs = 1'b1;
    tif.cfg_valid = 1'b1; tif.cfg_auto = 1'b0; tif.cfg_pat = 4'd7; tif.cfg_dwell = 8'd0;
    @(negedge clk);
    fexp = fexp + 1'b1;
    nvec++; if (tif.pat_sel !== 4'd4) begin nerr++; $display("FAIL sim_adv_sel: got %0d want 4", tif.pat_sel); end
    nvec++; if (tif.pat_upd !== 1'b1) begin nerr++; $display("FAIL sim_adv_upd: got %0b want 1", tif.pat_upd); end
    nvec++; if (tif.cfg_ready !== 1'b0) begin nerr++; $display("FAIL sim_ready: got %0b want 0", tif.cfg_ready); end
    nvec++; if (tif.auto_md !== 1'b1) begin nerr++; $display("FAIL sim_auto: got %0b want 1", tif.auto_md); end
    vs = 1'b0;
    tif.cfg_pat = 4'd9; tif.cfg_auto = 1'b1;
    repeat (2) @(negedge clk);
    tif.cfg_valid = 1'b0;
    vs_pulse(u, s, u2);
    nvec++; if (s !== 4'd7) begin nerr++; $display("FAIL sim_apply_sel: got %0d want 7", s); end
    nvec++; if (u !== 1'b1) begin nerr++; $display("FAIL sim_apply_upd: got %0b want 1", u); end
    nvec++; if (tif.auto_md !== 1'b0) begin nerr++; $display("FAIL sim_apply_auto: got %0b want 0", tif.auto_md); end
    vs_pulse(u, s, u2);
    nvec++; if (s !== 4'd7) begin nerr++; $display("FAIL sim_2nd_sel: got %0d want 7", s); end
    nvec++; if (u !== 1'b0) begin nerr++; $display("FAIL sim_2nd_upd: got %0b want 0", u); end
    nvec++; if (tif.cfg_ready !== 1'b1) begin nerr++; $display("FAIL sim_2nd_ready: got %0b want 1", tif.cfg_ready); end
    nvec++; if (fcnt !== fexp) begin nerr++; $display("FAIL sim_fcnt: got %0d want %0d", fcnt, fexp); end
  endtask

  task automatic test_reset_mid();
    logic u, u2; logic [3:0] s;
    cfg(1'b1, 4'd2, 8'd3);
    vs_pulse(u, s, u2);
    nvec++; if (s !== 4'd2 || tif.auto_md !== 1'b1) begin nerr++; $display("FAIL rm_setup: got sel %0d auto %0b want 2/1", s, tif.auto_md); end
    cfg(1'b0, 4'd6, 8'd0);
    @(negedge clk); vs = 1'b1; rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    fexp = '0;
    @(negedge clk);
    nvec++; if (tif.pat_sel !== 4'd0) begin nerr++; $display("FAIL rm_sel: got %0d want 0", tif.pat_sel); end
    nvec++; if (tif.auto_md !== 1'b0) begin nerr++; $display("FAIL rm_auto: got %0b want 0", tif.auto_md); end
    nvec++; if (tif.cfg_ready !== 1'b1) begin nerr++; $display("FAIL rm_ready: got %0b want 1", tif.cfg_ready); end
    for (int i = 0; i < 3; i++) begin
      nvec++; if (tif.pat_upd !== 1'b0) begin nerr++; $display("FAIL rm_upd[%0d]: got %0b want 0", i, tif.pat_upd); end
      nvec++; if (fcnt !== '0) begin nerr++; $display("FAIL rm_fcnt[%0d]: got %0d want 0", i, fcnt); end
      @(negedge clk);
    end
    vs = 1'b0;
    @(negedge clk);
    vs_pulse(u, s, u2);
    nvec++; if (fcnt !== fexp) begin nerr++; $display("FAIL rm_edge_fcnt: got %0d want %0d", fcnt, fexp); end
    nvec++; if (u !== 1'b0 || s !== 4'd0) begin nerr++; $display("FAIL rm_no_apply: got upd %0b sel %0d want 0/0", u, s); end
  endtask

  task automatic test_wrap();
    logic [FW-1:0] ones;
    ones = '1;
    while (fexp != ones) begin
      @(negedge clk); vs = 1'b1;
      @(negedge clk); vs = 1'b0;
      fexp = fexp + 1'b1;
    end
    @(negedge clk);
    nvec++; if (fcnt !== ones) begin nerr++; $display("FAIL wrap_max: got %0d want %0d", fcnt, ones); end
    @(negedge clk); vs = 1'b1;
    @(negedge clk); vs = 1'b0;
    nvec++; if (fcnt !== '0) begin nerr++; $display("FAIL wrap_zero: got %0d want 0", fcnt); end
  endtask

  initial begin
    tif.cfg_valid = 1'b0; tif.cfg_auto = 1'b0; tif.cfg_pat = 4'd0; tif.cfg_dwell = 8'd0;
    fexp = '0;
    test_reset();
    test_manual();
    test_auto();
    test_dwell0();
    test_simul();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
